key_requester: RTL and testbench

- Initiator side of the req/req_key/ack key-match handshake; drives a responder whose 4-bit down-counter resets to all-ones and decrements every cycle.
- The responder asserts ack combinationally in the same cycle as req, when req_key equals its counter.
- This block keeps a shadow copy of that counter and issues bursts of requests with the predicted key.
- It scores each request as pass or fail and can deliberately inject wrong keys for negative testing.

---
 rtl/key_req_pkg.sv | 15 +
 rtl/key_mirror.sv | 23 ++
 rtl/key_requester.sv | 124 ++++++++++++
 tb/tb_key_requester.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/key_req_pkg.sv
// rtl/key_req_pkg.sv - shared state type and default widths for the key requester
package key_req_pkg;

  localparam int DEF_KEY_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/key_mirror.sv
// rtl/key_mirror.sv - shadow of the responder's free-running key down-counter
module key_mirror #(
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [KEY_W-1:0] shadow_o
);

  logic [KEY_W-1:0] cnt_q;

  // Must reset and step exactly like the responder so keys stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= cnt_q - KEY_W'(1);
    end
  end

  assign shadow_o = cnt_q;

endmodule

// File: rtl/key_requester.sv
// rtl/key_requester.sv - issues scored bursts of key-match requests to a responder
module key_requester
  import key_req_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic [GAP_W-1:0] gap,
  input  logic             inject_err,
  output logic             req,
  output logic [KEY_W-1:0] req_key,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] num_q,     num_d;
  logic [CNT_W-1:0] idx_q,     idx_d;
  logic [CNT_W-1:0] pass_q,    pass_d;
  logic [CNT_W-1:0] fail_q,    fail_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             inj_q,     inj_d;
  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] key_sel;

  key_mirror #(.KEY_W(KEY_W)) u_mirror (
    .clk      (clk),
    .rst      (rst),
    .shadow_o (shadow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      inj_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      inj_q     <= inj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    inj_d     = inj_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_txn;
          gap_d   = gap;
          inj_d   = inject_err;
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          state_d = (num_txn == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        // ack is only ever looked at here, at the edge closing a REQ cycle.
        if (ack) begin
          if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
        end else begin
          if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        end
        idx_d = idx_q + CNT_W'(1);
        if (idx_d == num_q) begin
          state_d = DONE;
        end else if (gap_q != '0) begin
          state_d   = GAP;
          gap_cnt_d = gap_q;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = REQ;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Odd-indexed requests get a key one ahead of the responder when injecting.
  assign key_sel  = (inj_q && idx_q[0]) ? shadow + KEY_W'(1) : shadow;
  assign req      = (state_q == REQ);
  assign req_key  = req ? key_sel : '0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_key_requester.sv
// tb/tb_key_requester.sv - directed bench for key_requester against a responder model
module tb_key_requester;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] num_txn;
  logic [3:0] gap;
  logic       inject_err;
  logic       req;
  logic [3:0] req_key;
  logic       ack;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;

  logic [3:0] resp_cnt;

  int n_cmp;
  int n_bad;

  int           n_req;
  int           n_ack;
  int           n_busy;
  int           n_done;
  int           done_cyc;
  logic [127:0] keys_pk;
  logic [63:0]  cyc_pk;

  key_requester dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_txn    (num_txn),
    .gap        (gap),
    .inject_err (inject_err),
    .req        (req),
    .req_key    (req_key),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: acks on key match; left ungated so stray acks outside REQ occur.
  always_ff @(posedge clk) begin
    if (rst) resp_cnt <= 4'hF;
    else     resp_cnt <= resp_cnt - 4'd1;
  end
  assign ack = (req_key == resp_cnt);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Leaves the bench in cycle 0, starts a run, and logs ncyc following cycles.
  task automatic run(input logic [7:0] n, input logic [3:0] g, input logic inj,
                     input int ncyc, input int pulse_at, input int rst_at);
    do_reset();
    num_txn = n;
    gap = g;
    inject_err = inj;
    start = 1'b1;
    n_req = 0; n_ack = 0; n_busy = 0; n_done = 0; done_cyc = -1;
    keys_pk = '0; cyc_pk = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (req) begin
        n_req++;
        if (ack) n_ack++;
        keys_pk = {keys_pk[123:0], req_key};
        cyc_pk  = {cyc_pk[55:0], 8'(c)};
      end
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (busy) n_busy++;
      if (c == pulse_at) begin
        start = 1'b1;
        num_txn = 8'd9;
      end
      if (c == rst_at) rst = 1'b1;
      if (c == rst_at + 1) begin
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_key", req_key, 0);
        rst = 1'b0;
        num_txn = 8'd5;
        gap = 4'd0;
        start = 1'b1;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    num_txn = '0;
    gap = '0;
    inject_err = 1'b0;

    do_reset();
    check("reset_req", req, 0);
    check("reset_key", req_key, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass_cnt, 0);
    check("reset_fail", fail_cnt, 0);

    run(8'd4, 4'd0, 1'b0, 8, -1, -1);
    check("basic_nreq", n_req, 4);
    check("basic_cycles", cyc_pk, 64'h01020304);
    check("basic_keys", keys_pk, 128'hEDCB);
    check("basic_acks", n_ack, 4);
    check("basic_done_cyc", done_cyc, 5);
    check("basic_done_cnt", n_done, 1);
    check("basic_busy", n_busy, 5);
    check("basic_pass", pass_cnt, 4);
    check("basic_fail", fail_cnt, 0);

    run(8'd3, 4'd2, 1'b0, 12, -1, -1);
    check("gap_cycles", cyc_pk, 64'h010407);
    check("gap_keys", keys_pk, 128'hEB8);
    check("gap_done_cyc", done_cyc, 8);
    check("gap_busy", n_busy, 8);
    check("gap_pass", pass_cnt, 3);
    check("gap_fail", fail_cnt, 0);

    run(8'd4, 4'd0, 1'b1, 8, -1, -1);
    check("inj_keys", keys_pk, 128'hEECC);
    check("inj_acks", n_ack, 2);
    check("inj_pass", pass_cnt, 2);
    check("inj_fail", fail_cnt, 2);

    run(8'd20, 4'd0, 1'b0, 24, -1, -1);
    check("wrap_nreq", n_req, 20);
    check("wrap_keys", keys_pk, 128'hEDCBA9876543210FEDCB);
    check("wrap_done_cyc", done_cyc, 21);
    check("wrap_pass", pass_cnt, 20);
    check("wrap_fail", fail_cnt, 0);

    run(8'd0, 4'd3, 1'b0, 20, -1, -1);
    check("zero_nreq", n_req, 0);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_done_cnt", n_done, 1);
    check("zero_busy", n_busy, 1);
    check("zero_pass", pass_cnt, 0);
    check("zero_fail", fail_cnt, 0);

    run(8'd3, 4'd1, 1'b0, 10, 2, -1);
    check("busy_start_cycles", cyc_pk, 64'h010305);
    check("busy_start_keys", keys_pk, 128'hECA);
    check("busy_start_done", done_cyc, 6);
    check("busy_start_pass", pass_cnt, 3);
    check("busy_start_busy", n_busy, 6);

    run(8'd10, 4'd0, 1'b0, 12, -1, 3);
    check("rerun_cycles", cyc_pk, 64'h0102030506070809);
    check("rerun_keys", keys_pk, 128'hEDCEDCBA);
    check("rerun_acks", n_ack, 8);
    check("rerun_done_cnt", n_done, 1);
    check("rerun_done_cyc", done_cyc, 10);
    check("rerun_pass", pass_cnt, 5);
    check("rerun_fail", fail_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
